// File: rtl/cordic_scheduler.sv
// cordic_scheduler
// Shares one iterative vectoring CORDIC between N_CH lock-in channels.
// One (I, Q) request is accepted at a time, in round-robin order.
// The request is handed to the CORDIC, and the scheduler waits for the result.
// Magnitude and phase are returned tagged with the requesting channel.
// If the CORDIC never answers, the conversion is abandoned after TIMEOUT cycles.
module cordic_scheduler #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 42,
  parameter int TIMEOUT = 63,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req_valid,
  output logic [N_CH-1:0]         req_ready,
  input  logic [N_CH*WIDTH-1:0]   req_I,
  input  logic [N_CH*WIDTH-1:0]   req_Q,
  output logic                    cordic_valid_in,
  output logic [WIDTH-1:0]        cordic_I,
  output logic [WIDTH-1:0]        cordic_Q,
  input  logic                    cordic_valid_out,
  input  logic [WIDTH-1:0]        cordic_phase,
  input  logic [WIDTH-1:0]        cordic_mag,
  output logic                    res_valid,
  output logic [CH_W-1:0]         res_ch,
  output logic [WIDTH-1:0]        res_phase,
  output logic [WIDTH-1:0]        res_mag,
  output logic                    timeout_err,
  output logic                    busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The abandon decision is taken on the edge that would carry the counter to TIMEOUT
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]       state_q,       state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [CH_W-1:0]  curCh_q,       curCh_d;
  logic [CH_W-1:0]  lastGrant_q,   lastGrant_d;
  logic             validIn_q,     validIn_d;
  logic [WIDTH-1:0] cordicI_q,     cordicI_d;
  logic [WIDTH-1:0] cordicQ_q,     cordicQ_d;
  logic             resValid_q,    resValid_d;
  logic [CH_W-1:0]  resCh_q,       resCh_d;
  logic [WIDTH-1:0] resPhase_q,    resPhase_d;
  logic [WIDTH-1:0] resMag_q,      resMag_d;
  logic             timeoutErr_q,  timeoutErr_d;

  logic [CH_W-1:0]  grant;
  logic [CH_W-1:0]  candidate;
  logic             anyReq;

  assign anyReq = |req_valid;

  // Round-robin search from lastGrant+1; scanning backwards lets the nearest requester win
  always_comb begin
    grant     = '0;
    candidate = '0;
    for (int k = N_CH; k >= 1; k--) begin
      candidate = CH_W'((int'(lastGrant_q) + k) % N_CH);
      if (req_valid[candidate]) begin
        grant = candidate;
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE && anyReq) ? (N_CH'(1) << grant) : '0;

  // Next-state logic for the IDLE/WAIT controller and all registered outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    curCh_d      = curCh_q;
    lastGrant_d  = lastGrant_q;
    validIn_d    = 1'b0;
    cordicI_d    = cordicI_q;
    cordicQ_d    = cordicQ_q;
    resValid_d   = 1'b0;
    resCh_d      = resCh_q;
    resPhase_d   = resPhase_q;
    resMag_d     = resMag_q;
    timeoutErr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (anyReq) begin
          cordicI_d   = req_I[int'(grant)*WIDTH +: WIDTH];
          cordicQ_d   = req_Q[int'(grant)*WIDTH +: WIDTH];
          validIn_d   = 1'b1;
          curCh_d     = grant;
          lastGrant_d = grant;
          cnt_d       = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cordic_valid_out) begin
          resPhase_d = cordic_phase;
          resMag_d   = cordic_mag;
          resCh_d    = curCh_q;
          resValid_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeoutErr_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset gives channel 0 first priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      curCh_q      <= '0;
      lastGrant_q  <= CH_W'(N_CH - 1);
      validIn_q    <= 1'b0;
      cordicI_q    <= '0;
      cordicQ_q    <= '0;
      resValid_q   <= 1'b0;
      resCh_q      <= '0;
      resPhase_q   <= '0;
      resMag_q     <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      curCh_q      <= curCh_d;
      lastGrant_q  <= lastGrant_d;
      validIn_q    <= validIn_d;
      cordicI_q    <= cordicI_d;
      cordicQ_q    <= cordicQ_d;
      resValid_q   <= resValid_d;
      resCh_q      <= resCh_d;
      resPhase_q   <= resPhase_d;
      resMag_q     <= resMag_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  assign cordic_valid_in = validIn_q;
  assign cordic_I        = cordicI_q;
  assign cordic_Q        = cordicQ_q;
  assign res_valid       = resValid_q;
  assign res_ch          = resCh_q;
  assign res_phase       = resPhase_q;
  assign res_mag         = resMag_q;
  assign timeout_err     = timeoutErr_q;
  assign busy            = (state_q == ST_WAIT);

endmodule

// File: tb/tb_cordic_scheduler.sv
// tb_cordic_scheduler
// Directed bench for cordic_scheduler with a behavioural CORDIC stand-in.
// The stand-in answers a programmable number of cycles after a start pulse.
// A delay of 0 makes it never answer.
module tb_cordic_scheduler;

  localparam int N_CH    = 4;
  localparam int WIDTH   = 42;
  localparam int TIMEOUT = 63;
  localparam int CH_W    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_CH-1:0]       req_valid;
  logic [N_CH-1:0]       req_ready;
  logic [N_CH*WIDTH-1:0] req_I;
  logic [N_CH*WIDTH-1:0] req_Q;
  logic                  cordicValidIn;
  logic [WIDTH-1:0]      cordicI;
  logic [WIDTH-1:0]      cordicQ;
  logic                  cordicValidOut = 1'b0;
  logic [WIDTH-1:0]      cordicPhase = '0;
  logic [WIDTH-1:0]      cordicMag = '0;
  logic                  res_valid;
  logic [CH_W-1:0]       res_ch;
  logic [WIDTH-1:0]      res_phase;
  logic [WIDTH-1:0]      res_mag;
  logic                  timeout_err;
  logic                  busy;

  int               stubDelay = 42;
  int               stubCnt = 0;
  logic             spurReq = 1'b0;
  logic [WIDTH-1:0] stubPhase = '0;
  logic [WIDTH-1:0] stubMag = '0;

  int passCount = 0;
  int checkCount = 0;
  int badReady = 0;

  cordic_scheduler #(.N_CH(N_CH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_I            (req_I),
    .req_Q            (req_Q),
    .cordic_valid_in  (cordicValidIn),
    .cordic_I         (cordicI),
    .cordic_Q         (cordicQ),
    .cordic_valid_out (cordicValidOut),
    .cordic_phase     (cordicPhase),
    .cordic_mag       (cordicMag),
    .res_valid        (res_valid),
    .res_ch           (res_ch),
    .res_phase        (res_phase),
    .res_mag          (res_mag),
    .timeout_err      (timeout_err),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Behavioural CORDIC: answers stubDelay edges after sampling a start, or on a forced spurious pulse
  always @(posedge clk) begin
    cordicValidOut <= 1'b0;
    if (spurReq) begin
      cordicValidOut <= 1'b1;
      cordicPhase    <= stubPhase;
      cordicMag      <= stubMag;
    end
    if (cordicValidIn && stubDelay != 0) begin
      stubCnt <= stubDelay;
    end else if (stubCnt != 0) begin
      stubCnt <= stubCnt - 1;
      if (stubCnt == 1) begin
        cordicValidOut <= 1'b1;
        cordicPhase    <= stubPhase;
        cordicMag      <= stubMag;
      end
    end
  end

  // Watch for any accept offered while a conversion is in flight
  always @(negedge clk) begin
    if (busy && req_ready != '0) badReady++;
  end

  // Hard stop in case something stalls the directed sequence
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] mask);
    req_valid = mask;
  endtask

  // One full conversion: offer mask, expect channel ch granted, result after expLat negedges
  task automatic runOne(input logic [N_CH-1:0] mask, input int ch,
                        input logic [WIDTH-1:0] iVal, input logic [WIDTH-1:0] qVal,
                        input logic [WIDTH-1:0] phase, input logic [WIDTH-1:0] mag,
                        input int expLat);
    int n;
    int toSeen;
    stubPhase = phase;
    stubMag   = mag;
    req_I[ch*WIDTH +: WIDTH] = iVal;
    req_Q[ch*WIDTH +: WIDTH] = qVal;
    applyStimulus(mask);
    #1;
    checkOutput($sformatf("ready ch%0d", ch), req_ready, N_CH'(1) << ch);
    @(negedge clk);
    n = 1;
    toSeen = 0;
    checkOutput("start pulse", cordicValidIn, 1'b1);
    checkOutput("busy in wait", busy, 1'b1);
    checkOutput("ready in wait", req_ready, '0);
    checkOutput("cordic I", cordicI, iVal);
    checkOutput("cordic Q", cordicQ, qVal);
    applyStimulus('0);
    @(negedge clk);
    n = 2;
    checkOutput("start one cycle", cordicValidIn, 1'b0);
    while (res_valid !== 1'b1 && n < 150) begin
      @(negedge clk);
      n++;
      if (timeout_err === 1'b1) toSeen++;
    end
    checkOutput($sformatf("latency ch%0d", ch), n, expLat);
    checkOutput("no timeout", toSeen, 0);
    checkOutput("res ch", res_ch, ch);
    checkOutput("res phase", res_phase, phase);
    checkOutput("res mag", res_mag, mag);
    @(negedge clk);
    checkOutput("res pulse one cycle", res_valid, 1'b0);
    checkOutput("no err after result", timeout_err, 1'b0);
    checkOutput("idle after result", busy, 1'b0);
    checkOutput("res mag holds", res_mag, mag);
  endtask

  initial begin
    int n;
    int seen;
    logic [WIDTH-1:0] halfPi;
    logic [WIDTH-1:0] quarterPi;
    logic [WIDTH-1:0] negFive;
    halfPi    = 42'd1 << 38;
    quarterPi = 42'd1 << 37;
    negFive   = -42'sd5;
    reset     = 1'b1;
    req_valid = '0;
    req_I     = '0;
    req_Q     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset res_valid", res_valid, 1'b0);
    checkOutput("reset res_ch", res_ch, 0);
    checkOutput("reset res_phase", res_phase, 0);
    checkOutput("reset res_mag", res_mag, 0);
    checkOutput("reset timeout_err", timeout_err, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset start", cordicValidIn, 1'b0);
    checkOutput("reset ready", req_ready, '0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single requests");
    runOne(4'b0001, 0, 42'd1000, 42'd0, 42'd0, 42'd1647, 45);
    runOne(4'b0100, 2, 42'd0, 42'd1000, halfPi, 42'd1647, 45);
    runOne(4'b1000, 3, negFive, 42'd7, 42'd99, 42'd8, 45);

    $display("[TB] round robin with all channels requesting");
    stubPhase = 42'd11;
    stubMag   = 42'd1647;
    applyStimulus(4'b1111);
    #1;
    checkOutput("rr first grant", req_ready, 4'b0001);
    for (int k = 1; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (req_ready == '0 && n < 100);
      checkOutput($sformatf("rr spacing %0d", k), n, 45);
      checkOutput($sformatf("rr grant %0d", k), req_ready, N_CH'(1) << (k % N_CH));
    end
    @(negedge clk);
    applyStimulus('0);
    n = 1;
    while (res_valid !== 1'b1 && n < 150) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rr last latency", n, 45);
    checkOutput("rr last ch", res_ch, 0);
    @(negedge clk);
    checkOutput("no ready while busy", badReady, 0);

    $display("[TB] CORDIC never answers");
    stubDelay = 0;
    applyStimulus(4'b0010);
    #1;
    checkOutput("to ready", req_ready, 4'b0010);
    @(negedge clk);
    applyStimulus('0);
    n = 1;
    seen = 0;
    while (timeout_err !== 1'b1 && n < 150) begin
      @(negedge clk);
      n++;
      if (res_valid === 1'b1) seen++;
    end
    checkOutput("timeout cycle", n, 64);
    checkOutput("no result on timeout", seen, 0);
    checkOutput("res ch holds", res_ch, 0);
    checkOutput("res mag holds", res_mag, 42'd1647);
    checkOutput("res phase holds", res_phase, 42'd11);
    @(negedge clk);
    checkOutput("timeout one cycle", timeout_err, 1'b0);
    checkOutput("idle after timeout", busy, 1'b0);
    stubDelay = 42;
    runOne(4'b0100, 2, 42'd300, 42'd400, 42'd55, 42'd823, 45);

    $display("[TB] spurious done pulse in idle");
    stubPhase = 42'h123;
    stubMag   = 42'h456;
    spurReq   = 1'b1;
    @(negedge clk);
    spurReq = 1'b0;
    @(negedge clk);
    checkOutput("spur no result", res_valid, 1'b0);
    checkOutput("spur no error", timeout_err, 1'b0);
    checkOutput("spur stays idle", busy, 1'b0);
    checkOutput("spur phase holds", res_phase, 42'd55);
    checkOutput("spur ch holds", res_ch, 2);

    $display("[TB] result coincides with timeout");
    stubDelay = 61;
    runOne(4'b1000, 3, 42'd5, 42'd6, 42'd77, 42'd88, 64);
    stubDelay = 42;
    runOne(4'b0001, 0, 42'd1000, 42'd1000, quarterPi, 42'd2329, 45);

    $display("[TB] reset during wait");
    stubPhase = 42'h777;
    stubMag   = 42'h777;
    req_I[0 +: WIDTH] = 42'd55;
    applyStimulus(4'b0001);
    #1;
    checkOutput("pre-reset ready", req_ready, 4'b0001);
    @(negedge clk);
    applyStimulus('0);
    repeat (9) @(negedge clk);
    checkOutput("pre-reset busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async busy", busy, 1'b0);
    checkOutput("async res_phase", res_phase, 0);
    checkOutput("async res_mag", res_mag, 0);
    checkOutput("async res_ch", res_ch, 0);
    checkOutput("async cordic I", cordicI, 0);
    checkOutput("async res_valid", res_valid, 1'b0);
    checkOutput("async timeout_err", timeout_err, 1'b0);
    checkOutput("async start", cordicValidIn, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1 || timeout_err === 1'b1) seen++;
    end
    checkOutput("late result ignored", seen, 0);
    checkOutput("late phase ignored", res_phase, 0);
    runOne(4'b0011, 0, 42'd9, 42'd9, 42'h2A, 42'h15, 45);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
